// File: rtl/dm_stage.sv
// Data-memory stage: 256x8 data RAM, registered writeback to the register file.
// Define DM_MMIO_EN to map a handshaked output port at 0xFF and an input port at 0xFE.
module dm_stage (
  input  logic       sig_clk,
  input  logic       sig_rst,
  input  logic [7:0] EX_data_result,
  input  logic [7:0] EX_data_reg,
  input  logic [1:0] EX_addr_reg,
  input  logic [1:0] EX_sig_ctrl_DM,
  input  logic       EX_sig_ctrl_RF,
  input  logic [7:0] IO_data_in,
  input  logic       IO_sig_ready,
  output logic [7:0] RF_data_wr,
  output logic [1:0] RF_addr_wr,
  output logic       RF_sig_wr,
  output logic [7:0] IO_data_out,
  output logic       IO_sig_valid,
  output logic       PL_sig_stall
);

  logic [7:0] ram_r [0:255];
  logic       is_load_s;
  logic       is_store_s;
  logic       ram_we_s;
  logic [7:0] load_data_s;
  logic [7:0] wb_data_s;
  logic       wb_en_s;
  logic [7:0] rf_data_r;
  logic [1:0] rf_addr_r;
  logic       rf_wr_r;

  // Decode the memory operation; 00 and 11 both pass the ALU result through.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    case (EX_sig_ctrl_DM)
      2'b01:   is_load_s  = 1'b1;
      2'b10:   is_store_s = 1'b1;
      default: begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
      end
    endcase
  end

`ifdef DM_MMIO_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_FULL = 1'b1} port_state_e;

  port_state_e state_r;
  port_state_e state_nxt_s;
  logic [7:0]  io_data_r;
  logic        io_store_s;
  logic        io_accept_s;
  logic        stall_s;
  logic        io_valid_s;

  assign io_valid_s = (state_r == ST_FULL);

  // Address decode: 0xFE/0xFF never reach the RAM; a port store stalls only when it cannot be accepted.
  always_comb begin
    io_store_s  = is_store_s && (EX_data_result == 8'hFF);
    ram_we_s    = is_store_s && (EX_data_result < 8'hFE);
    stall_s     = io_store_s && io_valid_s && !IO_sig_ready;
    io_accept_s = io_store_s && !stall_s;
    if (EX_data_result == 8'hFE) begin
      load_data_s = IO_data_in;
    end else if (EX_data_result == 8'hFF) begin
      load_data_s = {7'b0000000, io_valid_s};
    end else begin
      load_data_s = ram_r[EX_data_result];
    end
  end

  // Output port next state; a fresh store wins over a completing handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (io_accept_s) state_nxt_s = ST_FULL;
        else             state_nxt_s = ST_IDLE;
      end
      ST_FULL: begin
        if (io_accept_s)       state_nxt_s = ST_FULL;
        else if (IO_sig_ready) state_nxt_s = ST_IDLE;
        else                   state_nxt_s = ST_FULL;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output port state and data; data only changes on an accepted store so it holds under backpressure.
  always_ff @(posedge sig_clk or posedge sig_rst) begin
    if (sig_rst) begin
      state_r   <= ST_IDLE;
      io_data_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      if (io_accept_s) io_data_r <= EX_data_reg;
    end
  end

  assign IO_data_out  = io_data_r;
  assign IO_sig_valid = io_valid_s;
  assign PL_sig_stall = stall_s;
`else
  logic unused_io_s;

  assign unused_io_s = ^{IO_data_in, IO_sig_ready};

  // Without the port every address is plain RAM.
  always_comb begin
    ram_we_s    = is_store_s;
    load_data_s = ram_r[EX_data_result];
  end

  assign IO_data_out  = 8'h00;
  assign IO_sig_valid = 1'b0;
  assign PL_sig_stall = 1'b0;
`endif

  // Writeback selection; stores (including stalled port stores) never write the register file.
  always_comb begin
    wb_data_s = is_load_s ? load_data_s : EX_data_result;
    wb_en_s   = EX_sig_ctrl_RF && !is_store_s;
  end

  // Data RAM write port; contents are intentionally left unreset.
  always_ff @(posedge sig_clk) begin
    if (ram_we_s) ram_r[EX_data_result] <= EX_data_reg;
  end

  // Writeback register; also the forwarding source for earlier stages.
  always_ff @(posedge sig_clk or posedge sig_rst) begin
    if (sig_rst) begin
      rf_data_r <= 8'h00;
      rf_addr_r <= 2'b00;
      rf_wr_r   <= 1'b0;
    end else begin
      rf_data_r <= wb_data_s;
      rf_addr_r <= EX_addr_reg;
      rf_wr_r   <= wb_en_s;
    end
  end

  assign RF_data_wr = rf_data_r;
  assign RF_addr_wr = rf_addr_r;
  assign RF_sig_wr  = rf_wr_r;

endmodule

// File: tb/tb_dm_stage.sv
// Scoreboard bench for dm_stage: stimulus pushes expected writeback/port state, a monitor pops and compares.
module tb_dm_stage;

`ifdef DM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  logic       sig_clk = 1'b0;
  logic       sig_rst = 1'b1;
  logic [7:0] EX_data_result = 8'h00;
  logic [7:0] EX_data_reg = 8'h00;
  logic [1:0] EX_addr_reg = 2'b00;
  logic [1:0] EX_sig_ctrl_DM = 2'b00;
  logic       EX_sig_ctrl_RF = 1'b0;
  logic [7:0] IO_data_in = 8'h00;
  logic       IO_sig_ready = 1'b0;
  logic [7:0] RF_data_wr;
  logic [1:0] RF_addr_wr;
  logic       RF_sig_wr;
  logic [7:0] IO_data_out;
  logic       IO_sig_valid;
  logic       PL_sig_stall;

  typedef struct {
    logic       cd;   // check data/address (not meaningful for stores)
    logic [7:0] d;
    logic [1:0] a;
    logic       w;
    logic       v;
    logic [7:0] iod;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  dm_stage dut (
    .sig_clk(sig_clk), .sig_rst(sig_rst),
    .EX_data_result(EX_data_result), .EX_data_reg(EX_data_reg),
    .EX_addr_reg(EX_addr_reg), .EX_sig_ctrl_DM(EX_sig_ctrl_DM),
    .EX_sig_ctrl_RF(EX_sig_ctrl_RF), .IO_data_in(IO_data_in),
    .IO_sig_ready(IO_sig_ready), .RF_data_wr(RF_data_wr),
    .RF_addr_wr(RF_addr_wr), .RF_sig_wr(RF_sig_wr),
    .IO_data_out(IO_data_out), .IO_sig_valid(IO_sig_valid),
    .PL_sig_stall(PL_sig_stall)
  );

  always #5 sig_clk = ~sig_clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: apply one op, check the combinational stall, queue the post-edge expectation.
  task automatic step(input logic [1:0] dm, input logic [7:0] res, input logic [7:0] dat,
                      input logic [1:0] ra, input logic rf, input logic xs, input exp_t e);
    EX_sig_ctrl_DM = dm;
    EX_data_result = res;
    EX_data_reg    = dat;
    EX_addr_reg    = ra;
    EX_sig_ctrl_RF = rf;
    #1;
    chk("stall", {7'd0, PL_sig_stall}, {7'd0, xs});
    exp_q.push_back(e);
    @(negedge sig_clk);
  endtask

  function automatic exp_t ex(input logic cd, input logic [7:0] d, input logic [1:0] a,
                              input logic w, input logic v, input logic [7:0] iod);
    exp_t e;
    e.cd = cd; e.d = d; e.a = a; e.w = w; e.v = v; e.iod = iod;
    return e;
  endfunction

  // Monitor: the writeback register presents a result every edge outside reset.
  always @(posedge sig_clk) begin
    exp_t e;
    #1;
    if (!sig_rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rf_sig_wr", {7'd0, RF_sig_wr}, {7'd0, e.w});
      if (e.cd) begin
        chk("rf_data_wr", RF_data_wr, e.d);
        chk("rf_addr_wr", {6'd0, RF_addr_wr}, {6'd0, e.a});
      end
      chk("io_sig_valid", {7'd0, IO_sig_valid}, {7'd0, e.v});
      if (e.v || !MMIO) chk("io_data_out", IO_data_out, e.iod);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rf_data"}, RF_data_wr, 8'h00);
    chk({tag, "_rf_addr"}, {6'd0, RF_addr_wr}, 8'h00);
    chk({tag, "_rf_wr"}, {7'd0, RF_sig_wr}, 8'h00);
    chk({tag, "_io_data"}, IO_data_out, 8'h00);
    chk({tag, "_io_valid"}, {7'd0, IO_sig_valid}, 8'h00);
    chk({tag, "_stall"}, {7'd0, PL_sig_stall}, 8'h00);
  endtask

  initial begin
    #2;
    check_reset_outputs("por");
    repeat (2) @(negedge sig_clk);
    sig_rst = 1'b0;

    // RAM store/load, pass, store-suppresses-writeback, wrap and overwrite.
    step(OP_STORE, 8'h10, 8'h5A, 2'd3, 1'b1, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00));
    step(OP_LOAD,  8'h10, 8'h00, 2'd2, 1'b1, 1'b0, ex(1'b1, 8'h5A, 2'd2, 1'b1, 1'b0, 8'h00));
    step(OP_PASS,  8'h33, 8'h00, 2'd1, 1'b1, 1'b0, ex(1'b1, 8'h33, 2'd1, 1'b1, 1'b0, 8'h00));
    step(OP_STORE, 8'h11, 8'h66, 2'd1, 1'b1, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00));
    step(2'b11,    8'h44, 8'h00, 2'd0, 1'b0, 1'b0, ex(1'b1, 8'h44, 2'd0, 1'b0, 1'b0, 8'h00));
    step(OP_STORE, 8'h00, 8'h12, 2'd0, 1'b0, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00));
    step(OP_STORE, 8'hFD, 8'hEE, 2'd0, 1'b0, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00));
    step(OP_LOAD,  8'h00, 8'h00, 2'd3, 1'b1, 1'b0, ex(1'b1, 8'h12, 2'd3, 1'b1, 1'b0, 8'h00));
    step(OP_LOAD,  8'hFD, 8'h00, 2'd0, 1'b1, 1'b0, ex(1'b1, 8'hEE, 2'd0, 1'b1, 1'b0, 8'h00));
    step(OP_STORE, 8'h20, 8'h01, 2'd0, 1'b0, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00));
    step(OP_STORE, 8'h20, 8'h02, 2'd0, 1'b0, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00));
    step(OP_LOAD,  8'h20, 8'h00, 2'd1, 1'b1, 1'b0, ex(1'b1, 8'h02, 2'd1, 1'b1, 1'b0, 8'h00));
    step(OP_LOAD,  8'h10, 8'h00, 2'd2, 1'b0, 1'b0, ex(1'b1, 8'h5A, 2'd2, 1'b0, 1'b0, 8'h00));

`ifdef DM_MMIO_EN
    // Port handshake, backpressure stall, input port and status reads.
    IO_data_in = 8'hC3; IO_sig_ready = 1'b0;
    step(OP_LOAD,  8'hFE, 8'h00, 2'd0, 1'b1, 1'b0, ex(1'b1, 8'hC3, 2'd0, 1'b1, 1'b0, 8'h00));
    step(OP_STORE, 8'hFF, 8'hA1, 2'd2, 1'b1, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 8'hA1));
    step(OP_LOAD,  8'hFF, 8'h00, 2'd1, 1'b1, 1'b0, ex(1'b1, 8'h01, 2'd1, 1'b1, 1'b1, 8'hA1));
    step(OP_STORE, 8'hFF, 8'hB2, 2'd0, 1'b1, 1'b1, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 8'hA1));
    step(OP_STORE, 8'hFF, 8'hB2, 2'd0, 1'b1, 1'b1, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 8'hA1));
    IO_sig_ready = 1'b1;
    step(OP_STORE, 8'hFF, 8'hB2, 2'd0, 1'b1, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 8'hB2));
    step(OP_PASS,  8'h00, 8'h00, 2'd0, 1'b0, 1'b0, ex(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00));
    IO_sig_ready = 1'b0;
    step(OP_LOAD,  8'hFF, 8'h00, 2'd3, 1'b1, 1'b0, ex(1'b1, 8'h00, 2'd3, 1'b1, 1'b0, 8'h00));
    step(OP_STORE, 8'hFE, 8'h99, 2'd0, 1'b0, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00));
    IO_data_in = 8'h3C;
    step(OP_LOAD,  8'hFE, 8'h00, 2'd2, 1'b1, 1'b0, ex(1'b1, 8'h3C, 2'd2, 1'b1, 1'b0, 8'h00));
    step(OP_STORE, 8'hFF, 8'hA1, 2'd0, 1'b0, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 8'hA1));
    step(OP_LOAD,  8'hFF, 8'h00, 2'd3, 1'b1, 1'b0, ex(1'b1, 8'h01, 2'd3, 1'b1, 1'b1, 8'hA1));
    // Stalled port store in flight when reset arrives between edges.
    EX_sig_ctrl_DM = OP_STORE; EX_data_result = 8'hFF; EX_data_reg = 8'hB2;
    EX_addr_reg = 2'd0; EX_sig_ctrl_RF = 1'b1;
    #1;
    chk("pre_reset_stall", {7'd0, PL_sig_stall}, 8'h01);
`else
    // Without the port, 0xFF is ordinary RAM and the IO inputs have no effect.
    IO_data_in = 8'h55; IO_sig_ready = 1'b0;
    step(OP_STORE, 8'hFF, 8'h77, 2'd0, 1'b0, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00));
    step(OP_STORE, 8'hFE, 8'h88, 2'd0, 1'b0, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00));
    step(OP_LOAD,  8'hFF, 8'h00, 2'd3, 1'b1, 1'b0, ex(1'b1, 8'h77, 2'd3, 1'b1, 1'b0, 8'h00));
    IO_sig_ready = 1'b1;
    step(OP_STORE, 8'hFF, 8'h78, 2'd0, 1'b0, 1'b0, ex(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00));
    step(OP_LOAD,  8'hFE, 8'h00, 2'd1, 1'b1, 1'b0, ex(1'b1, 8'h88, 2'd1, 1'b1, 1'b0, 8'h00));
    step(OP_LOAD,  8'hFF, 8'h00, 2'd2, 1'b1, 1'b0, ex(1'b1, 8'h78, 2'd2, 1'b1, 1'b0, 8'h00));
    EX_sig_ctrl_DM = OP_PASS; EX_data_result = 8'h00; EX_sig_ctrl_RF = 1'b0;
    #1;
`endif

    // Asynchronous reset: outputs clear with no clock edge in between.
    sig_rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge sig_clk);
    EX_sig_ctrl_DM = OP_PASS; EX_data_result = 8'h00; EX_data_reg = 8'h00;
    EX_addr_reg = 2'd0; EX_sig_ctrl_RF = 1'b0; IO_sig_ready = 1'b0;
    sig_rst = 1'b0;
    step(OP_PASS,  8'h33, 8'h00, 2'd1, 1'b1, 1'b0, ex(1'b1, 8'h33, 2'd1, 1'b1, 1'b0, 8'h00));
    step(OP_LOAD,  8'h10, 8'h00, 2'd2, 1'b1, 1'b0, ex(1'b1, 8'h5A, 2'd2, 1'b1, 1'b0, 8'h00));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge sig_clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_stage.md
DM_STAGE -- requirements
Module: dm_stage

Interface
REQ-001 sig_clk  input  1  single clock; all state updates on rising edge.
REQ-002 sig_rst  input  1  reset, asynchronous, active-high.
REQ-003 EX_data_result  input  8  ALU result / memory address from execute stage.
REQ-004 EX_data_reg  input  8  store data (operand A) from execute stage.
REQ-005 EX_addr_reg  input  2  destination register index.
REQ-006 EX_sig_ctrl_DM  input  2  memory op: 00 pass, 01 load, 10 store, 11 pass.
REQ-007 EX_sig_ctrl_RF  input  1  register-file write request for this op.
REQ-008 IO_data_in  input  8  external input port value.
REQ-009 IO_sig_ready  input  1  output-port consumer ready.
REQ-010 RF_data_wr  output  8  registered writeback data; also the forwarding source.
REQ-011 RF_addr_wr  output  2  registered writeback register index.
REQ-012 RF_sig_wr  output  1  registered writeback enable.
REQ-013 IO_data_out  output  8  output-port data.
REQ-014 IO_sig_valid  output  1  output-port data valid.
REQ-015 PL_sig_stall  output  1  combinational stall request to IF/ID/EX; upstream holds inputs while high.

Function
REQ-016 Data RAM: 256 x 8, addressed by EX_data_result, synchronous write, synchronous read.
REQ-017 Pass op: next edge RF_data_wr=EX_data_result, RF_addr_wr=EX_addr_reg, RF_sig_wr=EX_sig_ctrl_RF; latency 1 cycle.
REQ-018 Load op: next edge RF_data_wr=RAM[EX_data_result], RF_addr_wr/RF_sig_wr as pass; latency 1 cycle.
REQ-019 Store op: RAM[EX_data_result]<=EX_data_reg at edge; RF_sig_wr=0 next cycle regardless of EX_sig_ctrl_RF.
REQ-020 Store then load same address in consecutive cycles: load returns newly stored value.
REQ-021 Address wrap: 8-bit addressing only, no out-of-range condition.
REQ-022 MMIO (when enabled): store to 0xFF targets output port, not RAM; load from 0xFE returns IO_data_in sampled at the edge; load from 0xFF returns {7'b0, IO_sig_valid}; store to 0xFE ignored.
REQ-023 Output port states: IDLE (valid=0), FULL (valid=1); IDLE->FULL on store 0xFF; FULL->IDLE on valid&ready edge with no new store.
REQ-024 Store 0xFF in IDLE: IO_data_out<=EX_data_reg, IO_sig_valid<=1 next edge, no stall.
REQ-025 Store 0xFF in FULL with IO_sig_ready=1: handshake completes and new data accepted same edge; valid stays 1, no stall.
REQ-026 Store 0xFF in FULL with IO_sig_ready=0: PL_sig_stall=1 same cycle; RF_sig_wr=0 next edge (bubble); store retried each cycle until ready.
REQ-027 IO_data_out stable while IO_sig_valid=1 and IO_sig_ready=0.
REQ-028 PL_sig_stall is 0 for every op other than REQ-026.

Reset
REQ-029 While sig_rst high: RF_data_wr=0, RF_addr_wr=0, RF_sig_wr=0, IO_data_out=0, IO_sig_valid=0, PL_sig_stall=0.
REQ-030 Reset mid-handshake drops IO_sig_valid immediately; pending data discarded.
REQ-031 RAM contents not reset; undefined after power-up.

Configuration
REQ-032 Macro DM_MMIO_EN: defined -> REQ-022..REQ-028 apply; undefined -> 0xFE/0xFF are ordinary RAM, IO_data_out=0, IO_sig_valid=0, PL_sig_stall=0, IO inputs ignored.

Verification
REQ-033 Store 0x5A to 0x10, then load 0x10 into r2 -> next cycle RF_data_wr=0x5A, RF_addr_wr=2, RF_sig_wr=1.
REQ-034 Pass 0x33 with RF=1, r1 -> next cycle RF_data_wr=0x33, RF_addr_wr=1, RF_sig_wr=1; store with RF=1 -> RF_sig_wr=0.
REQ-035 MMIO: store 0xA1 to 0xFF, ready=0; store 0xB2 to 0xFF -> stall=1, IO_data_out=0xA1 held; ready=1 -> 0xB2 accepted, stall=0, valid=1.
REQ-036 MMIO: IO_data_in=0xC3, load 0xFE -> RF_data_wr=0xC3; with valid=1 load 0xFF -> RF_data_wr=0x01.
REQ-037 Assert sig_rst while valid=1, ready=0 -> valid=0, stall=0, RF outputs 0 without clock edge.
REQ-038 Without DM_MMIO_EN: store 0x77 to 0xFF, load 0xFF -> RF_data_wr=0x77; IO_sig_valid stays 0.
